// File: rtl/sprite_motion.sv
// Bouncing 4x4 sprite motion generator: frame-tick divider plus an erase/move/draw
// command sequencer feeding a plotter over a valid/ready handshake.
module sprite_motion #(
   parameter int CLK_HZ   = 50000000,
   parameter int FRAME_HZ = 60,
   parameter int X_MAX    = 124,
   parameter int Y_MAX    = 116
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] speed,
   input  logic       pause,
   input  logic       out_ready,
   output logic       out_valid,
   output logic       out_erase,
   output logic [7:0] out_x,
   output logic [6:0] out_y,
   output logic [2:0] out_colour,
   output logic       frame_tick,
   output logic       overrun
);

   localparam int             DIV      = CLK_HZ / FRAME_HZ;
   localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);
   localparam logic [6:0]     XM       = 7'(X_MAX);
   localparam logic [6:0]     YM       = 7'(Y_MAX);

   // Handshake: a command is transferred in any cycle where out_valid && out_ready
   // are both high; while out_valid is high and out_ready low, every out_* signal
   // holds its value.
   typedef enum logic [1:0] {S_WAIT, S_ERASE, S_MOVE, S_DRAW} state_t;

   state_t        state, state_n;
   logic [CW-1:0] div_cnt;
   logic [6:0]    pos_x, pos_y, pos_x_n, pos_y_n;
   logic          dir_x, dir_y, dir_x_n, dir_y_n;
   logic [2:0]    col, col_n, skip, skip_n;
   logic [7:0]    step_x, step_y;
   logic          overrun_n;
   logic          valid_n, erase_n;
   logic [7:0]    x_n;
   logic [6:0]    y_n;
   logic [2:0]    colour_n;

   // Returns {new_dir, new_pos}; a change of direction marks a bounce.
   function automatic logic [7:0] step_axis(input logic [6:0] pos, input logic dir,
                                            input logic [6:0] lim);
      logic [7:0] r;
      if (!dir) begin
         if (pos == lim) r = {1'b1, lim - 7'd1};
         else            r = {1'b0, pos + 7'd1};
      end else begin
         if (pos == 7'd0) r = {1'b0, 7'd1};
         else             r = {1'b1, pos - 7'd1};
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt    <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= (div_cnt == DIV_LAST);
         div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
      end
   end

   always_comb begin
      step_x = step_axis(pos_x, dir_x, XM);
      step_y = step_axis(pos_y, dir_y, YM);
   end

   always_comb begin
      state_n   = state;
      pos_x_n   = pos_x;
      pos_y_n   = pos_y;
      dir_x_n   = dir_x;
      dir_y_n   = dir_y;
      col_n     = col;
      skip_n    = skip;
      overrun_n = overrun;
      valid_n   = out_valid;
      erase_n   = out_erase;
      x_n       = out_x;
      y_n       = out_y;
      colour_n  = out_colour;

      case (state)
         S_WAIT: begin
            if (frame_tick && !pause) begin
               // >= keeps the count from stalling if speed is lowered mid-count
               if (skip >= speed) begin
                  skip_n   = 3'd0;
                  state_n  = S_ERASE;
                  valid_n  = 1'b1;
                  erase_n  = 1'b1;
                  x_n      = {1'b0, pos_x};
                  y_n      = pos_y;
                  colour_n = 3'd0;
               end else begin
                  skip_n = skip + 3'd1;
               end
            end
         end
         S_ERASE: begin
            if (out_ready) begin
               state_n = S_MOVE;
               valid_n = 1'b0;
            end
         end
         S_MOVE: begin
            pos_x_n = step_x[6:0];
            dir_x_n = step_x[7];
            pos_y_n = step_y[6:0];
            dir_y_n = step_y[7];
            if ((step_x[7] != dir_x) || (step_y[7] != dir_y))
               col_n = (col == 3'd7) ? 3'd1 : col + 3'd1;
            state_n  = S_DRAW;
            valid_n  = 1'b1;
            erase_n  = 1'b0;
            x_n      = {1'b0, step_x[6:0]};
            y_n      = step_y[6:0];
            colour_n = ((step_x[7] != dir_x) || (step_y[7] != dir_y)) ?
                       ((col == 3'd7) ? 3'd1 : col + 3'd1) : col;
         end
         S_DRAW: begin
            if (out_ready) begin
               state_n = S_WAIT;
               valid_n = 1'b0;
            end
         end
         default: begin
            state_n = S_WAIT;
            valid_n = 1'b0;
         end
      endcase

      // Ticks landing mid-sequence are dropped, only flagged.
      if (frame_tick && (state != S_WAIT))
         overrun_n = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_WAIT;
         pos_x      <= 7'd0;
         pos_y      <= 7'd0;
         dir_x      <= 1'b0;
         dir_y      <= 1'b0;
         col        <= 3'd1;
         skip       <= 3'd0;
         overrun    <= 1'b0;
         out_valid  <= 1'b0;
         out_erase  <= 1'b0;
         out_x      <= 8'd0;
         out_y      <= 7'd0;
         out_colour <= 3'd0;
      end else begin
         state      <= state_n;
         pos_x      <= pos_x_n;
         pos_y      <= pos_y_n;
         dir_x      <= dir_x_n;
         dir_y      <= dir_y_n;
         col        <= col_n;
         skip       <= skip_n;
         overrun    <= overrun_n;
         out_valid  <= valid_n;
         out_erase  <= erase_n;
         out_x      <= x_n;
         out_y      <= y_n;
         out_colour <= colour_n;
      end
   end

endmodule
